spi_word_master: RTL and testbench

SPI mode-0 host that converts parallel command words into serial frames on SCK/CS/COPI and returns the word captured on CIPO. It sits directly upstream of the rapcore SPI slave (`spi.v` / `spi_state_machine.v`). It lets an on-chip or harness-side controller issue multi-word RAPcore commands through a valid/ready handshake instead of bit-banging. Frames are MSB first, and CS can be held low across consecutive words to form multi-word transactions.

---
 rtl/spi_word_master.sv | 176 +++++++++++++++++
 tb/tb_spi_word_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_master.sv
// SPI mode-0 host: parallel command words out on COPI, MSB first,
// with the word seen on CIPO during the same frame returned on rx_data.
//
// Ports:
//   CLK, RESET       system clock, synchronous active-high reset
//   tx_data/tx_last  word to send; tx_last releases CS after this word
//   tx_valid/ready   input handshake (ready only in IDLE and GAP)
//   rx_data/valid    captured word, one-cycle pulse per frame
//   busy             CS low or CS idle gap in progress
//   SCK, CS, COPI    serial outputs (SCK idles low, CS active low)
//   CIPO             serial input
module spi_word_master #(
  parameter int WORD_W   = 64,
  parameter int HALF_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCK,
  output logic              CS,
  output logic              COPI,
  input  logic              CIPO
);

  localparam int M1    = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
  localparam int CMAX  = (M1 > CS_IDLE) ? M1 : CS_IDLE;
  localparam int CNT_W = $clog2(CMAX);
  localparam int BIT_W = $clog2(WORD_W);

  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LO,
    S_HI,
    S_GAP,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] rxd_q, rxd_d;
  logic              last_q, last_d;
  logic              rxv_q, rxv_d;
  logic              cs_low;
  logic              accept;

  assign cs_low = state_q inside {S_SETUP, S_LO, S_HI, S_GAP};
  assign SCK    = (state_q == S_HI);
  assign CS     = ~cs_low;
  // tx_q MSB is the bit on the wire; it only moves on SCK fall or load.
  assign COPI   = cs_low & tx_q[WORD_W-1];
  assign busy   = (state_q != S_IDLE);
  assign tx_ready = ~RESET &
                    ((state_q == S_IDLE) || (state_q == S_GAP));
  assign accept = tx_valid & tx_ready;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      last_q  <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      last_q  <= last_d;
      rxv_q   <= rxv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    last_d  = last_q;
    rxv_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_d    = tx_data;
          last_d  = tx_last;
          bit_d   = BIT_LD;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = HALF_LD;
          state_d = S_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LO: begin
        if (cnt_q == '0) begin
          // SCK rises on this edge: capture CIPO.
          rx_d    = {rx_q[WORD_W-2:0], CIPO};
          cnt_d   = HALF_LD;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HI: begin
        if (cnt_q == '0) begin
          if (bit_q == '0) begin
            // Final fall: no shift, so COPI keeps the last bit in GAP.
            rxd_d = rx_q;
            rxv_d = 1'b1;
            if (last_q) begin
              cnt_d   = IDLE_LD;
              state_d = S_WAIT;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            tx_d    = {tx_q[WORD_W-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            cnt_d   = HALF_LD;
            state_d = S_LO;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (accept) begin
          tx_d    = tx_data;
          last_d  = tx_last;
          bit_d   = BIT_LD;
          cnt_d   = HALF_LD;
          state_d = S_LO;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_word_master.sv
// Directed + randomized bench for spi_word_master, with a mode-0 slave
// model and a second minimum-parameter instance.
module tb_spi_word_master;

  localparam int W = 64, HD = 4, CSS = 2, CSI = 4;
  localparam int MW = 8, MHD = 2, MCSS = 1, MCSI = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET;
  logic [W-1:0]  tx_data, rx_data;
  logic          tx_last, tx_valid, tx_ready, rx_valid, busy;
  logic          SCK, CS, COPI, CIPO;
  logic [MW-1:0] m_tx_data, m_rx_data;
  logic          m_tx_last, m_tx_valid, m_tx_ready, m_rx_valid, m_busy;
  logic          m_SCK, m_CS, m_COPI, m_CIPO;

  bit           loop_en;
  logic [W-1:0] slv_sh, slv_rx, slv_resp;
  assign CIPO   = loop_en ? COPI : slv_sh[W-1];
  assign m_CIPO = m_COPI;

  spi_word_master #(.WORD_W(W), .HALF_DIV(HD),
                    .CS_SETUP(CSS), .CS_IDLE(CSI)) dut (
    .CLK(CLK), .RESET(RESET), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .SCK(SCK), .CS(CS),
    .COPI(COPI), .CIPO(CIPO));

  spi_word_master #(.WORD_W(MW), .HALF_DIV(MHD),
                    .CS_SETUP(MCSS), .CS_IDLE(MCSI)) dmin (
    .CLK(CLK), .RESET(RESET), .tx_data(m_tx_data),
    .tx_last(m_tx_last), .tx_valid(m_tx_valid),
    .tx_ready(m_tx_ready), .rx_data(m_rx_data),
    .rx_valid(m_rx_valid), .busy(m_busy), .SCK(m_SCK), .CS(m_CS),
    .COPI(m_COPI), .CIPO(m_CIPO));

  int tests = 0, fails = 0;
  int sck_r = 0, cs_f = 0, cs_r = 0, rxv_n = 0, rdy_hi = 0;
  int cs_lo = 0, m_sck_r = 0;
  logic [W-1:0] rx_log[$];

  // Mode-0 slave: samples COPI on rise, shifts CIPO on fall.
  always @(posedge SCK) begin
    sck_r++;
    slv_rx = {slv_rx[W-2:0], COPI};
  end
  always @(negedge SCK) if (CS === 1'b0) slv_sh = slv_sh << 1;
  always @(negedge CS) begin
    cs_f++;
    slv_sh = slv_resp;
  end
  always @(posedge CS) cs_r++;
  always @(posedge m_SCK) m_sck_r++;
  always @(negedge CLK) begin
    if (rx_valid === 1'b1) begin
      rxv_n++;
      rx_log.push_back(rx_data);
    end
    if (SCK === 1'b1 && tx_ready === 1'b1) rdy_hi++;
    if (CS === 1'b0) cs_lo++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    tx_data = d;
    tx_last = last;
    tx_valid = 1'b1;
    while (!tx_ready && n < 4000) begin tick(); n++; end
    if (n >= 4000) chk1("send_timeout", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_cs_high();
    int n;
    n = 0;
    while (!CS && n < 4000) begin tick(); n++; end
    if (n >= 4000) chk1("cs_rise_timeout", CS, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (n >= 100) chk1("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int n, b, first, s0, v0, f0, r0, h0, l0, q0, bad;
    logic [W-1:0] wd, wd2, resp;
    logic [W-1:0] w[3];

    RESET = 1'b1;
    tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    m_tx_valid = 1'b0; m_tx_data = '0; m_tx_last = 1'b0;
    loop_en = 1'b1;
    slv_resp = '0;
    repeat (3) tick();
    chk1("rst_tx_ready", tx_ready, 1'b0);
    chk1("rst_cs", CS, 1'b1);
    chk1("rst_sck", SCK, 1'b0);
    chk1("rst_copi", COPI, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, '0);
    RESET = 1'b0;
    tick();
    chk1("post_rst_ready", tx_ready, 1'b1);

    // Single-word loopback.
    s0 = sck_r; v0 = rxv_n;
    wd = 64'h0123_4567_89AB_CDEF;
    send(wd, 1'b1);
    n = 0; first = -1;
    while (!CS && n < 4000) begin
      if (SCK && first < 0) first = n;
      n++;
      tick();
    end
    chki("a_cs_low_cycles", n, CSS + W * 2 * HD);
    chki("a_first_rise", first, CSS + HD);
    chk1("a_rx_valid_edge", rx_valid, 1'b1);
    chk("a_rx_data", rx_data, wd);
    chk1("a_copi_wait", COPI, 1'b0);
    b = 0;
    while (busy && b < 100) begin b++; tick(); end
    chki("a_busy_tail", b, CSI);
    chki("a_sck_rises", sck_r - s0, W);
    chki("a_rx_pulses", rxv_n - v0, 1);

    // Slave model responses.
    loop_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp = (k == 0) ? 64'hA5A5_0000_FFFF_1234
                      : {$urandom, $urandom};
      wd = {$urandom, $urandom};
      slv_resp = resp;
      send(wd, 1'b1);
      wait_cs_high();
      chk("b_rx_data", rx_data, resp);
      chk("b_copi_bits", slv_rx, wd);
      wait_idle();
    end
    loop_en = 1'b1;

    // Three-word transaction, tx_valid held high.
    for (int i = 0; i < 3; i++) w[i] = {$urandom, $urandom};
    s0 = sck_r; v0 = rxv_n; f0 = cs_f; r0 = cs_r;
    h0 = rdy_hi; l0 = cs_lo; q0 = rx_log.size();
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = w[i];
      tx_last = (i == 2);
      n = 0;
      while (!tx_ready && n < 4000) begin tick(); n++; end
      if (n >= 4000) chk1("c_ready_timeout", tx_ready, 1'b1);
      tick();
    end
    tx_valid = 1'b0;
    wait_cs_high();
    tick();
    chki("c_cs_falls", cs_f - f0, 1);
    chki("c_cs_rises", cs_r - r0, 1);
    chki("c_sck_rises", sck_r - s0, 3 * W);
    chki("c_rx_pulses", rxv_n - v0, 3);
    chki("c_ready_in_frame", rdy_hi - h0, 0);
    chki("c_cs_low_cycles", cs_lo - l0, CSS + 3 * W * 2 * HD + 2);
    for (int i = 0; i < 3; i++)
      if (rx_log.size() > q0 + i) chk("c_rx_word", rx_log[q0 + i], w[i]);
      else chki("c_rx_missing", rx_log.size(), q0 + 3);
    wait_idle();

    // Stall in GAP, then second word without setup.
    wd = {$urandom, $urandom};
    wd2 = {$urandom, $urandom};
    f0 = cs_f;
    send(wd, 1'b0);
    n = 0;
    while (!tx_ready && n < 4000) begin tick(); n++; end
    chk("d_rx_word1", rx_data, wd);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (CS !== 1'b0 || SCK !== 1'b0 || COPI !== wd[0]) bad++;
      tick();
    end
    chki("d_gap_hold", bad, 0);
    s0 = sck_r;
    send(wd2, 1'b1);
    n = 0;
    while (!SCK && n < 100) begin n++; tick(); end
    chki("d_first_rise", n, HD);
    wait_cs_high();
    chk("d_rx_word2", rx_data, wd2);
    chki("d_sck_rises", sck_r - s0, W);
    chki("d_cs_falls", cs_f - f0, 1);
    wait_idle();

    // Reset mid-frame.
    wd = {$urandom, $urandom};
    s0 = sck_r;
    send(wd, 1'b1);
    n = 0;
    while (sck_r - s0 < 10 && n < 4000) begin tick(); n++; end
    tick();
    v0 = rxv_n;
    RESET = 1'b1;
    tick();
    chk1("e_cs", CS, 1'b1);
    chk1("e_sck", SCK, 1'b0);
    chk1("e_copi", COPI, 1'b0);
    chk1("e_rx_valid", rx_valid, 1'b0);
    chk1("e_tx_ready", tx_ready, 1'b0);
    RESET = 1'b0;
    tick();
    chk1("e_ready_after", tx_ready, 1'b1);
    chk("e_rx_data", rx_data, '0);
    chki("e_no_pulse", rxv_n - v0, 0);
    wd2 = {$urandom, $urandom};
    send(wd2, 1'b1);
    wait_cs_high();
    chk("e_fresh_rx", rx_data, wd2);
    wait_idle();

    // Minimum parameters, two single-word transactions.
    s0 = m_sck_r;
    m_tx_data = 8'h81; m_tx_last = 1'b1; m_tx_valid = 1'b1;
    n = 0;
    while (!m_tx_ready && n < 100) begin tick(); n++; end
    tick();
    m_tx_data = 8'h7E;
    n = 0;
    while (!m_CS && n < 1000) begin n++; tick(); end
    chki("f_cs_low1", n, MCSS + MW * 2 * MHD);
    chk1("f_rx_valid1", m_rx_valid, 1'b1);
    chk("f_rx1", W'(m_rx_data), W'(8'h81));
    b = 0;
    while (m_CS && b < 100) begin b++; tick(); end
    chki("f_cs_high_gap", b, MCSI + 1);
    m_tx_valid = 1'b0;
    n = 0;
    while (!m_CS && n < 1000) begin n++; tick(); end
    chki("f_cs_low2", n, MCSS + MW * 2 * MHD);
    chk("f_rx2", W'(m_rx_data), W'(8'h7E));
    chki("f_sck_rises", m_sck_r - s0, 2 * MW);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
